if_fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS pipeline. It holds the program counter, drives cur_pc to the next-PC selector, and issues fetch requests to instruction memory with a ready handshake. It buffers a returned instruction while decode is stalled and loads the IF/ID pipeline register. It also loads the next PC, and discards wrong-path fetches when a branch or jump redirect arrives.

---
 rtl/if_fetch_stage_pkg.sv | 20 ++
 rtl/if_fetch_stage_if.sv | 23 ++
 rtl/if_fetch_stage_if_id_reg.sv | 44 ++++
 rtl/if_fetch_stage.sv | 145 ++++++++++++++
 tb/tb_if_fetch_stage.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: reset PC, NOP word, FSM encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package if_fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

  // FETCH: request outstanding; WAIT_HOLD: instruction captured while decode is stalled
  typedef enum logic {
    FETCH     = 1'b0,
    WAIT_HOLD = 1'b1
  } fetch_state_t;

  // Retired-fetch counter increment; wraps modulo 2^32
  function automatic logic [31:0] cnt_inc(input logic [31:0] v);
    return v + 32'd1;
  endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory fetch bus: request/address out, ready/data back.
// Latency: imem_ready may arrive any number of cycles after imem_req.
// Backpressure: requester holds imem_addr until imem_ready or it abandons the request.
interface if_fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register with load, flush (NOP insertion) and hold.
// Latency: 1 cycle from load/flush to outputs.
// Backpressure: neither load nor flush asserted holds contents (decode stall).
module if_id_reg
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic        i_flush,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc4,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc4,
  output logic        o_valid
);

  logic [31:0] r_instr;
  logic [31:0] r_pc4;
  logic        r_valid;

  // Flush wins over load; a flush keeps the old PC+4 since the slot carries no instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr <= NOP_INSTR;
      r_pc4   <= 32'd0;
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_instr <= i_instr;
      r_pc4   <= i_pc4;
      r_valid <= 1'b1;
    end
  end

  assign o_instr = r_instr;
  assign o_pc4   = r_pc4;
  assign o_valid = r_valid;

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: PC register, imem request, stall hold buffer, IF/ID load.
// Latency: instruction reaches IF/ID on the edge imem_ready is seen; 1 instr/cycle back-to-back.
// Backpressure: decode stall parks a returned instruction in the hold buffer and drops imem_req.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           next_addr,
  input  logic [31:0]           pc_plus4,
  input  logic                  redirect,
  input  logic                  stall,
  if_fetch_stage_if.master      imem,
  output logic [31:0]           cur_pc,
  output logic [31:0]           id_instr,
  output logic [31:0]           id_pc_4,
  output logic                  id_valid,
  output logic [31:0]           fetch_cnt
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  logic [31:0]  r_pc;
  logic [31:0]  r_hold_instr;
  logic [31:0]  r_hold_pc4;
  logic [31:0]  r_fetch_cnt;

  logic         w_req;
  logic         w_id_load;
  logic         w_id_from_hold;
  logic         w_id_flush;
  logic         w_pc_load;
  logic         w_hold_cap;
  logic [31:0]  w_id_instr_in;
  logic [31:0]  w_id_pc4_in;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FETCH;
    else        r_state <= w_state_nxt;
  end

  // Next-state: redirect always returns to FETCH; stall on a returning fetch parks in WAIT_HOLD
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FETCH: begin
        if (!redirect && imem.imem_ready && stall) w_state_nxt = WAIT_HOLD;
      end
      WAIT_HOLD: begin
        if (redirect || !stall) w_state_nxt = FETCH;
      end
      default: w_state_nxt = FETCH;
    endcase
  end

  // Output/control decode; redirect has top priority and drops any same-cycle response
  always_comb begin
    w_req          = 1'b0;
    w_id_load      = 1'b0;
    w_id_from_hold = 1'b0;
    w_id_flush     = 1'b0;
    w_pc_load      = 1'b0;
    w_hold_cap     = 1'b0;
    case (r_state)
      FETCH: begin
        w_req = 1'b1;
        if (redirect) begin
          w_id_flush = 1'b1;
          w_pc_load  = 1'b1;
        end else if (imem.imem_ready && !stall) begin
          w_id_load  = 1'b1;
          w_pc_load  = 1'b1;
        end else if (imem.imem_ready) begin
          w_hold_cap = 1'b1;
        end else if (!stall) begin
          w_id_flush = 1'b1;
        end
      end
      WAIT_HOLD: begin
        if (redirect) begin
          w_id_flush = 1'b1;
          w_pc_load  = 1'b1;
        end else if (!stall) begin
          w_id_load      = 1'b1;
          w_id_from_hold = 1'b1;
          w_pc_load      = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // PC register and retired-fetch counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= RESET_PC;
      r_fetch_cnt <= 32'd0;
    end else begin
      if (w_pc_load) r_pc <= next_addr;
      if (w_id_load) r_fetch_cnt <= cnt_inc(r_fetch_cnt);
    end
  end

  // Hold buffer: captures a response during stall, cleared when a redirect discards it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_instr <= NOP_INSTR;
      r_hold_pc4   <= 32'd0;
    end else if (redirect) begin
      r_hold_instr <= NOP_INSTR;
      r_hold_pc4   <= 32'd0;
    end else if (w_hold_cap) begin
      r_hold_instr <= imem.imem_rdata;
      r_hold_pc4   <= pc_plus4;
    end
  end

  assign w_id_instr_in = w_id_from_hold ? r_hold_instr : imem.imem_rdata;
  assign w_id_pc4_in   = w_id_from_hold ? r_hold_pc4   : pc_plus4;

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_id_load),
    .i_flush (w_id_flush),
    .i_instr (w_id_instr_in),
    .i_pc4   (w_id_pc4_in),
    .o_instr (id_instr),
    .o_pc4   (id_pc_4),
    .o_valid (id_valid)
  );

  // Request is forced low while reset is held so the memory never sees a stale fetch
  assign imem.imem_req  = w_req & rst_n;
  assign imem.imem_addr = r_pc;
  assign cur_pc         = r_pc;
  assign fetch_cnt      = r_fetch_cnt;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios plus randomized traffic vs a reference model.
// Latency: model advances once per rising edge; outputs sampled 1 ns after the edge.
// Backpressure: imem_ready and stall are driven by the bench.
module tb_if_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] next_addr;
  logic [31:0] pc_plus4;
  logic        redirect;
  logic        stall;
  logic [31:0] cur_pc;
  logic [31:0] id_instr;
  logic [31:0] id_pc_4;
  logic        id_valid;
  logic [31:0] fetch_cnt;

  if_fetch_stage_if imem_bus ();

  if_fetch_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .next_addr (next_addr),
    .pc_plus4  (pc_plus4),
    .redirect  (redirect),
    .stall     (stall),
    .imem      (imem_bus.master),
    .cur_pc    (cur_pc),
    .id_instr  (id_instr),
    .id_pc_4   (id_pc_4),
    .id_valid  (id_valid),
    .fetch_cnt (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: PC, an optional parked instruction, the IF/ID slot and a load counter
  logic [31:0] m_pc;
  bit          m_held;
  logic [31:0] m_hold_instr;
  logic [31:0] m_hold_pc4;
  logic [31:0] m_id_instr;
  logic [31:0] m_id_pc4;
  bit          m_id_valid;
  logic [31:0] m_cnt;

  task automatic model_reset();
    m_pc = RST_PC; m_held = 0; m_hold_instr = NOP; m_hold_pc4 = 0;
    m_id_instr = NOP; m_id_pc4 = 0; m_id_valid = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    if (redirect) begin
      m_pc = next_addr; m_held = 0; m_id_valid = 0; m_id_instr = NOP;
    end else if (m_held) begin
      if (!stall) begin
        m_id_instr = m_hold_instr; m_id_pc4 = m_hold_pc4; m_id_valid = 1;
        m_pc = next_addr; m_cnt = m_cnt + 1; m_held = 0;
      end
    end else if (imem_bus.imem_ready) begin
      if (!stall) begin
        m_id_instr = imem_bus.imem_rdata; m_id_pc4 = pc_plus4; m_id_valid = 1;
        m_pc = next_addr; m_cnt = m_cnt + 1;
      end else begin
        m_held = 1; m_hold_instr = imem_bus.imem_rdata; m_hold_pc4 = pc_plus4;
      end
    end else if (!stall) begin
      m_id_valid = 0; m_id_instr = NOP;
    end
  endtask

  // Non-redirect next_addr is sequential; selector outputs come from the model PC
  task automatic drive(input bit rdy, input logic [31:0] rd, input bit stl,
                       input bit rdr, input logic [31:0] tgt);
    imem_bus.imem_ready = rdy;
    imem_bus.imem_rdata = rd;
    stall     = stl;
    redirect  = rdr;
    pc_plus4  = m_pc + 32'd4;
    next_addr = rdr ? tgt : m_pc + 32'd4;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    model_reset();
    #2;
    n_total++; if (imem_bus.imem_req !== 1'b0) $display("FAIL rst_req got %b want 0", imem_bus.imem_req); else n_pass++;
    n_total++; if (cur_pc !== RST_PC) $display("FAIL rst_pc got %h want %h", cur_pc, RST_PC); else n_pass++;
    n_total++; if (id_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", id_valid); else n_pass++;
    n_total++; if (id_instr !== NOP) $display("FAIL rst_instr got %h want %h", id_instr, NOP); else n_pass++;
    n_total++; if (id_pc_4 !== 32'd0) $display("FAIL rst_pc4 got %h want 0", id_pc_4); else n_pass++;
    n_total++; if (fetch_cnt !== 32'd0) $display("FAIL rst_cnt got %0d want 0", fetch_cnt); else n_pass++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0);
    #1;
    n_total++; if (imem_bus.imem_req !== 1'b1) $display("FAIL rel_req got %b want 1", imem_bus.imem_req); else n_pass++;
    n_total++; if (imem_bus.imem_addr !== RST_PC) $display("FAIL rel_addr got %h want %h", imem_bus.imem_addr, RST_PC); else n_pass++;
  endtask

  task automatic test_sequential();
    logic [31:0] rd;
    logic [31:0] exp_pc;
    for (int i = 0; i < 3; i++) begin
      rd = $urandom;
      exp_pc = RST_PC + 32'(4 * i);
      drive(1, rd, 0, 0, 0);
      n_total++; if (imem_bus.imem_addr !== exp_pc) $display("FAIL seq_addr%0d got %h want %h", i, imem_bus.imem_addr, exp_pc); else n_pass++;
      tick();
      n_total++; if (id_instr !== rd) $display("FAIL seq_instr%0d got %h want %h", i, id_instr, rd); else n_pass++;
      n_total++; if (id_pc_4 !== exp_pc + 32'd4) $display("FAIL seq_pc4%0d got %h want %h", i, id_pc_4, exp_pc + 32'd4); else n_pass++;
      n_total++; if (id_valid !== 1'b1) $display("FAIL seq_valid%0d got %b want 1", i, id_valid); else n_pass++;
    end
    n_total++; if (fetch_cnt !== 32'd3) $display("FAIL seq_cnt got %0d want 3", fetch_cnt); else n_pass++;
    n_total++; if (cur_pc !== 32'h300C) $display("FAIL seq_pc got %h want 0000300c", cur_pc); else n_pass++;
  endtask

  task automatic test_imem_wait();
    logic [31:0] rd;
    do_reset();
    drive(1, $urandom, 0, 0, 0);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(0, $urandom, 0, 0, 0);
      n_total++; if (imem_bus.imem_addr !== 32'h3004 || imem_bus.imem_req !== 1'b1) $display("FAIL wait_addr%0d got %h/%b want 00003004/1", i, imem_bus.imem_addr, imem_bus.imem_req); else n_pass++;
      tick();
      n_total++; if (id_valid !== 1'b0 || id_instr !== NOP) $display("FAIL wait_bubble%0d got %b/%h want 0/%h", i, id_valid, id_instr, NOP); else n_pass++;
      n_total++; if (cur_pc !== 32'h3004) $display("FAIL wait_pc%0d got %h want 00003004", i, cur_pc); else n_pass++;
    end
    rd = $urandom;
    drive(1, rd, 0, 0, 0);
    tick();
    n_total++; if (id_instr !== rd) $display("FAIL wait_instr got %h want %h", id_instr, rd); else n_pass++;
    n_total++; if (id_pc_4 !== 32'h3008) $display("FAIL wait_pc4 got %h want 00003008", id_pc_4); else n_pass++;
    n_total++; if (fetch_cnt !== 32'd2) $display("FAIL wait_cnt got %0d want 2", fetch_cnt); else n_pass++;
  endtask

  task automatic test_stall_hold();
    logic [31:0] prev_instr;
    prev_instr = m_id_instr;
    drive(1, 32'h8C01_0004, 1, 0, 0);
    tick();
    n_total++; if (imem_bus.imem_req !== 1'b0) $display("FAIL hold_req got %b want 0", imem_bus.imem_req); else n_pass++;
    n_total++; if (id_instr !== prev_instr || id_valid !== 1'b1) $display("FAIL hold_ifid got %h/%b want %h/1", id_instr, id_valid, prev_instr); else n_pass++;
    n_total++; if (cur_pc !== 32'h3008) $display("FAIL hold_pc got %h want 00003008", cur_pc); else n_pass++;
    drive(1, $urandom, 1, 0, 0);
    tick();
    n_total++; if (id_instr !== prev_instr || imem_bus.imem_req !== 1'b0) $display("FAIL hold2 got %h/%b want %h/0", id_instr, imem_bus.imem_req, prev_instr); else n_pass++;
    drive(0, 0, 0, 0, 0);
    tick();
    n_total++; if (id_instr !== 32'h8C01_0004) $display("FAIL unhold_instr got %h want 8c010004", id_instr); else n_pass++;
    n_total++; if (id_pc_4 !== 32'h300C || cur_pc !== 32'h300C) $display("FAIL unhold_pc got %h/%h want 0000300c", id_pc_4, cur_pc); else n_pass++;
    n_total++; if (fetch_cnt !== 32'd3 || imem_bus.imem_req !== 1'b1) $display("FAIL unhold_cnt got %0d/%b want 3/1", fetch_cnt, imem_bus.imem_req); else n_pass++;
  endtask

  task automatic test_redirect_stall();
    logic [31:0] cnt_before;
    drive(1, $urandom, 1, 0, 0);
    tick();
    cnt_before = m_cnt;
    drive(0, 0, 1, 1, 32'h3040);
    tick();
    n_total++; if (cur_pc !== 32'h3040) $display("FAIL rds_pc got %h want 00003040", cur_pc); else n_pass++;
    n_total++; if (id_valid !== 1'b0 || id_instr !== NOP) $display("FAIL rds_flush got %b/%h want 0/%h", id_valid, id_instr, NOP); else n_pass++;
    n_total++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h3040) $display("FAIL rds_req got %b/%h want 1/00003040", imem_bus.imem_req, imem_bus.imem_addr); else n_pass++;
    drive(0, 0, 0, 0, 0);
    tick();
    n_total++; if (id_valid !== 1'b0 || fetch_cnt !== cnt_before) $display("FAIL rds_discard got %b/%0d want 0/%0d", id_valid, fetch_cnt, cnt_before); else n_pass++;
  endtask

  task automatic test_redirect_ready();
    logic [31:0] cnt_before;
    cnt_before = m_cnt;
    drive(1, $urandom, 0, 1, 32'h3100);
    tick();
    n_total++; if (fetch_cnt !== cnt_before) $display("FAIL rdr_cnt got %0d want %0d", fetch_cnt, cnt_before); else n_pass++;
    n_total++; if (id_valid !== 1'b0) $display("FAIL rdr_valid got %b want 0", id_valid); else n_pass++;
    n_total++; if (imem_bus.imem_addr !== 32'h3100) $display("FAIL rdr_addr got %h want 00003100", imem_bus.imem_addr); else n_pass++;
  endtask

  task automatic test_async_reset();
    drive(1, $urandom, 1, 0, 0);
    tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_total++; if (cur_pc !== RST_PC) $display("FAIL arst_pc got %h want %h", cur_pc, RST_PC); else n_pass++;
    n_total++; if (id_valid !== 1'b0 || fetch_cnt !== 32'd0) $display("FAIL arst_regs got %b/%0d want 0/0", id_valid, fetch_cnt); else n_pass++;
    n_total++; if (imem_bus.imem_req !== 1'b0) $display("FAIL arst_req got %b want 0", imem_bus.imem_req); else n_pass++;
    drive(1, $urandom, 0, 0, 0);
    tick();
    n_total++; if (cur_pc !== RST_PC || fetch_cnt !== 32'd0 || id_valid !== 1'b0) $display("FAIL arst_late got %h/%0d/%b want %h/0/0", cur_pc, fetch_cnt, id_valid, RST_PC); else n_pass++;
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0);
    #1;
    n_total++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== RST_PC) $display("FAIL arst_rel got %b/%h want 1/%h", imem_bus.imem_req, imem_bus.imem_addr, RST_PC); else n_pass++;
  endtask

  task automatic test_random();
    bit rdy, stl, rdr;
    logic [31:0] tgt;
    for (int i = 0; i < 400; i++) begin
      rdy = ($urandom_range(0, 3) != 0);
      stl = ($urandom_range(0, 3) == 0);
      rdr = ($urandom_range(0, 7) == 0);
      tgt = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      drive(rdy, $urandom, stl, rdr, tgt);
      n_total++; if (imem_bus.imem_req !== !m_held || imem_bus.imem_addr !== m_pc) $display("FAIL rnd_req%0d got %b/%h want %b/%h", i, imem_bus.imem_req, imem_bus.imem_addr, !m_held, m_pc); else n_pass++;
      tick();
      n_total++; if (cur_pc !== m_pc) $display("FAIL rnd_pc%0d got %h want %h", i, cur_pc, m_pc); else n_pass++;
      n_total++; if (id_instr !== m_id_instr || id_valid !== m_id_valid) $display("FAIL rnd_ifid%0d got %h/%b want %h/%b", i, id_instr, id_valid, m_id_instr, m_id_valid); else n_pass++;
      n_total++; if (id_pc_4 !== m_id_pc4) $display("FAIL rnd_pc4%0d got %h want %h", i, id_pc_4, m_id_pc4); else n_pass++;
      n_total++; if (fetch_cnt !== m_cnt) $display("FAIL rnd_cnt%0d got %0d want %0d", i, fetch_cnt, m_cnt); else n_pass++;
    end
  endtask

  initial begin
    rst_n = 1'b1;
    model_reset();
    drive(0, 0, 0, 0, 0);
    #1;
    test_reset();
    test_sequential();
    test_imem_wait();
    test_stall_hold();
    test_redirect_stall();
    test_redirect_ready();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
